// File: rtl/ddr2_tst_pkg.sv
// Shared definitions for the DDR2 Avalon traffic generator/checker:
// FSM encoding, default pattern seed and the address-derived data pattern.
package ddr2_tst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [31:0] SEED_DEFAULT = 32'hA5C3_0F1E;

    // 64-bit pattern for a word address; callers truncate or zero-pad to DATA_W.
    function automatic logic [63:0] pattern64(input logic [31:0] a32, input logic [31:0] seed);
        return {seed ^ a32, ~a32};
    endfunction

endpackage

// File: rtl/ddr2_avl_pattern_gen_if.sv
// Avalon-MM local interface between the pattern generator (master) and the
// DDR2 controller (slave).
interface ddr2_avl_pattern_gen_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 64
);
    localparam int BE_W = DATA_W / 8;

    logic              avl_ready;
    logic              avl_burstbegin;
    logic [ADDR_W-1:0] avl_addr;
    logic [DATA_W-1:0] avl_wdata;
    logic [BE_W-1:0]   avl_be;
    logic              avl_read_req;
    logic              avl_write_req;
    logic              avl_size;
    logic              avl_rdata_valid;
    logic [DATA_W-1:0] avl_rdata;

    modport master (
        input  avl_ready, avl_rdata_valid, avl_rdata,
        output avl_burstbegin, avl_addr, avl_wdata, avl_be,
               avl_read_req, avl_write_req, avl_size
    );

    modport slave (
        output avl_ready, avl_rdata_valid, avl_rdata,
        input  avl_burstbegin, avl_addr, avl_wdata, avl_be,
               avl_read_req, avl_write_req, avl_size
    );
endinterface

// File: rtl/ddr2_pat_chk.sv
// Read-back checker: tracks the address of each returning beat, regenerates
// the expected pattern and counts mismatches one cycle after the beat.
module ddr2_pat_chk
    import ddr2_tst_pkg::*;
#(
    parameter int          ADDR_W = 24,
    parameter int          DATA_W = 64,
    parameter logic [31:0] SEED   = SEED_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              beat_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [15:0]       err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [63:0]       pat64;
    logic [DATA_W-1:0] exp_pat;

    assign pat64 = pattern64(32'(ret_q), SEED);

    if (DATA_W <= 64) begin : g_trunc
        assign exp_pat = pat64[DATA_W-1:0];
    end else begin : g_pad
        assign exp_pat = {{(DATA_W-64){1'b0}}, pat64};
    end

    // Next state: advance return address per beat, register the compare,
    // then count it (saturating) and keep only the first failing address.
    always_comb begin
        ret_d      = ret_q;
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
        err_d      = err_q;
        first_d    = first_q;
        if (clear_i) begin
            ret_d      = base_i;
            mis_addr_d = '0;
            err_d      = '0;
            first_d    = '0;
        end else begin
            if (beat_i) begin
                ret_d      = ret_q + ADDR_W'(1);
                mis_d      = (rdata_i != exp_pat);
                mis_addr_d = ret_q;
            end
            if (mis_q && err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (mis_q && err_q == 16'd0) begin
                first_d = mis_addr_q;
            end
        end
    end

    // Checker state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ret_q      <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            ret_q      <= ret_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign err_cnt_o        = err_q;
    assign first_err_addr_o = first_q;
endmodule

// File: rtl/ddr2_avl_pattern_gen.sv
// DDR2 Avalon-MM traffic generator: after calibration writes an
// address-derived pattern over [base, base+len), reads it back with up to
// MAX_OUT reads in flight and reports pass/fail.
//
// state    | meaning
// IDLE     | waiting for start after reset
// WAIT_CAL | run latched, waiting on controller calibration result
// WRITE    | one write per accepted beat over the region
// READ     | pipelined reads, throttled by outstanding count
// DONE     | result valid, held until the next start
module ddr2_avl_pattern_gen
    import ddr2_tst_pkg::*;
#(
    parameter int          ADDR_W  = 24,
    parameter int          DATA_W  = 64,
    parameter int          BE_W    = DATA_W / 8,
    parameter int          MAX_OUT = 8,
    parameter logic [31:0] SEED    = SEED_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             len,
    input  logic                          local_cal_success,
    input  logic                          local_cal_fail,
    ddr2_avl_pattern_gen_if.master        avl,
    output logic                          busy,
    output logic                          test_done,
    output logic                          test_pass,
    output logic [15:0]                   err_cnt,
    output logic [ADDR_W-1:0]             first_err_addr
);
    localparam int                OUT_W     = $clog2(MAX_OUT) + 1;
    localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              cal_fail_q, cal_fail_d;
    logic              fresh_q, fresh_d;

    logic              start_acc;
    logic              wr_req, rd_req, wr_acc, rd_acc, rd_beat, wr_last;
    logic [63:0]       pat64;
    logic [DATA_W-1:0] wpat;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign wr_req    = (state_q == ST_WRITE);
    // Throttle condition cannot drop while a read is stalled: outstanding
    // only grows on acceptance, issued count only on acceptance.
    assign rd_req    = (state_q == ST_READ) && (out_q < MAX_OUT_C) && (cnt_q < len_q);
    assign wr_acc    = wr_req && avl.avl_ready;
    assign rd_acc    = rd_req && avl.avl_ready;
    assign rd_beat   = (state_q == ST_READ) && avl.avl_rdata_valid;
    assign wr_last   = (cnt_q == (len_q - ADDR_W'(1)));

    assign pat64 = pattern64(32'(addr_q), SEED);

    if (DATA_W <= 64) begin : g_trunc
        assign wpat = pat64[DATA_W-1:0];
    end else begin : g_pad
        assign wpat = {{(DATA_W-64){1'b0}}, pat64};
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_WAIT_CAL;
            ST_WAIT_CAL: begin
                if (local_cal_fail)         state_d = ST_DONE;
                else if (local_cal_success) state_d = (len_q == '0) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE:    if (wr_acc && wr_last) state_d = ST_READ;
            ST_READ:     if (cnt_q == len_q && out_q == '0) state_d = ST_DONE;
            ST_DONE:     if (start) state_d = ST_WAIT_CAL;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM / bus outputs; write data is only driven while a write is presented.
    always_comb begin
        avl.avl_write_req  = wr_req;
        avl.avl_read_req   = rd_req;
        avl.avl_burstbegin = (wr_req || rd_req) && fresh_q;
        avl.avl_addr       = addr_q;
        avl.avl_wdata      = wr_req ? wpat : '0;
        avl.avl_be         = {BE_W{1'b1}};
        avl.avl_size       = 1'b1;
        busy               = (state_q == ST_WAIT_CAL) || (state_q == ST_WRITE) ||
                             (state_q == ST_READ);
        test_done          = (state_q == ST_DONE);
        test_pass          = (state_q == ST_DONE) && !cal_fail_q && (err_cnt == 16'd0);
    end

    // Datapath next state: command address, per-phase beat count,
    // outstanding reads and the burstbegin "new command" flag.
    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        cal_fail_d = cal_fail_q;
        // Next presented command is new unless this one is stalling.
        fresh_d    = !((wr_req || rd_req) && !avl.avl_ready);
        if (start_acc) begin
            base_d     = base_addr;
            len_d      = len;
            addr_d     = base_addr;
            cnt_d      = '0;
            out_d      = '0;
            cal_fail_d = 1'b0;
        end else begin
            if (state_q == ST_WAIT_CAL && local_cal_fail) cal_fail_d = 1'b1;
            if (wr_acc) begin
                if (wr_last) begin
                    addr_d = base_q;
                    cnt_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + ADDR_W'(1);
                end
            end
            if (rd_acc) begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + ADDR_W'(1);
            end
            if (state_q == ST_READ) begin
                unique case ({rd_acc, rd_beat})
                    2'b10:   out_d = out_q + OUT_W'(1);
                    2'b01:   if (out_q != '0) out_d = out_q - OUT_W'(1);
                    default: out_d = out_q;
                endcase
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            base_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            cal_fail_q <= 1'b0;
            fresh_q    <= 1'b1;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            cal_fail_q <= cal_fail_d;
            fresh_q    <= fresh_d;
        end
    end

    ddr2_pat_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_chk (
        .clk_i            (CLK),
        .rst_n_i          (nRST),
        .clear_i          (start_acc),
        .base_i           (base_addr),
        .beat_i           (rd_beat),
        .rdata_i          (avl.avl_rdata),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err_addr)
    );
endmodule

// File: tb/tb_ddr2_avl_pattern_gen.sv
// Bench for ddr2_avl_pattern_gen: an ideal memory model answers the Avalon
// bus; stimulus pushes expected commands and run results into queues and a
// monitor pops and compares them as the DUT presents them.
module tb_ddr2_avl_pattern_gen;
    localparam int          AW   = 24;
    localparam int          DW   = 64;
    localparam logic [31:0] SEED = 32'hA5C3_0F1E;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic          cal_s = 1'b0;
    logic          cal_f = 1'b0;
    logic          busy, test_done, test_pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    always #5 clk = ~clk;

    ddr2_avl_pattern_gen_if #(.ADDR_W(AW), .DATA_W(DW)) avl ();

    ddr2_avl_pattern_gen dut (
        .CLK               (clk),
        .nRST              (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .len               (len),
        .local_cal_success (cal_s),
        .local_cal_fail    (cal_f),
        .avl               (avl),
        .busy              (busy),
        .test_done         (test_done),
        .test_pass         (test_pass),
        .err_cnt           (err_cnt),
        .first_err_addr    (first_err_addr)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic          pass;
        logic [15:0]   err;
        logic [AW-1:0] first;
    } st_t;

    cmd_t exp_q[$];
    st_t  st_q[$];

    int n_vec = 0;
    int n_err = 0;

    // memory model controls
    bit rdy_rand = 1'b0;
    bit flip_en  = 1'b0;
    int lat      = 4;
    int tb_out   = 0;
    int max_out  = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] a32;
        a32 = {8'h00, a};
        return {SEED ^ a32, ~a32};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_burstbegin"}, 64'(avl.avl_burstbegin), 64'd0);
        chk({tag, "_addr"},       64'(avl.avl_addr),       64'd0);
        chk({tag, "_wdata"},      64'(avl.avl_wdata),      64'd0);
        chk({tag, "_be"},         64'(avl.avl_be),         64'hFF);
        chk({tag, "_rd_req"},     64'(avl.avl_read_req),   64'd0);
        chk({tag, "_wr_req"},     64'(avl.avl_write_req),  64'd0);
        chk({tag, "_size"},       64'(avl.avl_size),       64'd1);
        chk({tag, "_busy"},       64'(busy),               64'd0);
        chk({tag, "_done"},       64'(test_done),          64'd0);
        chk({tag, "_pass"},       64'(test_pass),          64'd0);
        chk({tag, "_err_cnt"},    64'(err_cnt),            64'd0);
        chk({tag, "_first_err"},  64'(first_err_addr),     64'd0);
    endtask

    // Memory model: stores accepted writes, returns reads after `lat` cycles,
    // optionally corrupting addresses 5 (bit 0) and 9 (bit 63).
    initial begin : mem_model
        logic          acc_wr, acc_rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        logic [15:0]   pv;
        logic [DW-1:0] pd [16];
        pv = '0;
        for (int i = 0; i < 16; i++) pd[i] = '0;
        avl.avl_ready       = 1'b0;
        avl.avl_rdata_valid = 1'b0;
        avl.avl_rdata       = '0;
        forever begin
            @(negedge clk);
            acc_wr = avl.avl_write_req && avl.avl_ready;
            acc_rd = avl.avl_read_req && avl.avl_ready;
            a      = avl.avl_addr;
            d      = avl.avl_wdata;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pv = '0;
            end else begin
                if (acc_wr) mem[a] = d;
                for (int i = 15; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                rd = '0;
                if (acc_rd) begin
                    rd = mem.exists(a) ? mem[a] : '0;
                    if (flip_en && a == 24'd5) rd[0]  = ~rd[0];
                    if (flip_en && a == 24'd9) rd[63] = ~rd[63];
                end
                pv[0] = acc_rd;
                pd[0] = rd;
            end
            avl.avl_rdata_valid = pv[lat-1];
            avl.avl_rdata       = pv[lat-1] ? pd[lat-1] : '0;
            avl.avl_ready       = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: command scoreboard, stall stability, burstbegin, outstanding
    // tracking and run-result scoreboard.
    initial begin : monitor
        logic          prev_stall, prev_done, req;
        logic          p_wr;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        cmd_t          e;
        st_t           s;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        p_wr = 1'b0; p_addr = '0; p_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                tb_out     = 0;
                continue;
            end
            req = avl.avl_write_req || avl.avl_read_req;
            if (req) begin
                chk("burstbegin", 64'(avl.avl_burstbegin), 64'(!prev_stall));
                if (prev_stall) begin
                    chk("stall_kind",  64'(avl.avl_write_req), 64'(p_wr));
                    chk("stall_addr",  64'(avl.avl_addr),      64'(p_addr));
                    chk("stall_wdata", avl.avl_wdata,          p_data);
                end
                if (avl.avl_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_cmd: got wr=%0b addr=%h, expected none",
                                 avl.avl_write_req, avl.avl_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_kind", 64'(avl.avl_write_req), 64'(e.wr));
                        chk("cmd_addr", 64'(avl.avl_addr), 64'(e.addr));
                        if (e.wr) chk("cmd_wdata", avl.avl_wdata, e.data);
                    end
                end
            end
            prev_stall = req && !avl.avl_ready;
            p_wr   = avl.avl_write_req;
            p_addr = avl.avl_addr;
            p_data = avl.avl_wdata;
            if (avl.avl_read_req && avl.avl_ready) tb_out++;
            if (avl.avl_rdata_valid && tb_out > 0) tb_out--;
            if (tb_out > max_out) max_out = tb_out;
            if (test_done && !prev_done) begin
                if (st_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got test_done, expected none");
                end else begin
                    s = st_q.pop_front();
                    chk("test_pass", 64'(test_pass), 64'(s.pass));
                    chk("err_cnt", 64'(err_cnt), 64'(s.err));
                    chk("first_err_addr", 64'(first_err_addr), 64'(s.first));
                end
            end
            prev_done = test_done;
        end
    end

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n, input bit traffic,
                          input bit rr, input bit fl, input int lt,
                          input logic ep, input logic [15:0] ee, input logic [AW-1:0] ef);
        cmd_t c;
        st_t  s;
        rdy_rand = rr;
        flip_en  = fl;
        lat      = lt;
        max_out  = 0;
        if (traffic) begin
            for (int i = 0; i < int'(n); i++) begin
                c.wr = 1'b1; c.addr = b + AW'(i); c.data = pat(c.addr);
                exp_q.push_back(c);
            end
            for (int i = 0; i < int'(n); i++) begin
                c.wr = 1'b0; c.addr = b + AW'(i); c.data = '0;
                exp_q.push_back(c);
            end
        end
        s.pass = ep; s.err = ee; s.first = ef;
        st_q.push_back(s);
        @(posedge clk);
        #1;
        base_addr = b;
        len       = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int bound);
        int k;
        k = 0;
        while (!test_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (!test_done) begin
            n_err++;
            $display("FAIL %s_timeout: got no test_done after %0d cycles, expected done", name, bound);
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_cmds_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_max_out_le8"}, 64'(max_out <= 8), 64'd1);
        exp_q.delete();
        st_q.delete();
    endtask

    initial begin : stimulus
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        cal_s = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run; a start pulse while busy must be ignored.
        launch(24'd0, 24'd16, 1'b1, 1'b0, 1'b0, 4, 1'b1, 16'd0, 24'd0);
        repeat (5) @(posedge clk);
        #1;
        base_addr = 24'h000123;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run("basic", 300);

        // Random stalls.
        launch(24'd0, 24'd16, 1'b1, 1'b1, 1'b0, 4, 1'b1, 16'd0, 24'd0);
        finish_run("stall", 600);

        // Corrupted read data at addresses 5 and 9.
        launch(24'd0, 24'd16, 1'b1, 1'b0, 1'b1, 4, 1'b0, 16'd2, 24'd5);
        finish_run("flip", 300);

        // Long latency: outstanding reads must saturate at exactly 8.
        launch(24'd0, 24'd16, 1'b1, 1'b0, 1'b0, 12, 1'b1, 16'd0, 24'd0);
        finish_run("throttle", 400);
        chk("throttle_max_out", 64'(max_out), 64'd8);

        // Calibration failure: DONE within 2 cycles, no traffic.
        cal_s = 1'b0;
        cal_f = 1'b1;
        launch(24'd0, 24'd16, 1'b0, 1'b0, 1'b0, 4, 1'b0, 16'd0, 24'd0);
        finish_run("calfail", 2);
        cal_f = 1'b0;
        cal_s = 1'b1;

        // Address wrap.
        launch(24'hFFFFFE, 24'd4, 1'b1, 1'b0, 1'b0, 4, 1'b1, 16'd0, 24'd0);
        finish_run("wrap", 200);

        // Zero length: immediate pass, no traffic.
        launch(24'h000040, 24'd0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 16'd0, 24'd0);
        finish_run("len0", 2);

        // Reset in READ with 5 reads outstanding.
        launch(24'd0, 24'd16, 1'b1, 1'b0, 1'b0, 8, 1'b1, 16'd0, 24'd0);
        k = 0;
        while (tb_out != 5 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (tb_out != 5) begin
            n_err++;
            $display("FAIL midrst_wait: got outstanding %0d, expected 5", tb_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        st_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(24'd0, 24'd16, 1'b1, 1'b0, 1'b0, 4, 1'b1, 16'd0, 24'd0);
        finish_run("after_rst", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish by 500000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
